// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point fixed-point FFT datapath.
// Provides the complex Q1.15 sample, conjugate twiddle ROM and bitrev3.
package fft_pkg;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int W     = 16;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_UNLOAD
    } state_t;

    // Conjugated twiddles exp(+j*2*pi*k/8) for the inverse transform
    localparam cplx_t TW0 = {16'h7FFF, 16'h0000};
    localparam cplx_t TW1 = {16'h5A82, 16'h5A82};
    localparam cplx_t TW2 = {16'h0000, 16'h7FFF};
    localparam cplx_t TW3 = {16'hA57E, 16'h5A82};

    function automatic cplx_t twiddle(input logic [1:0] k);
        cplx_t w;
        case (k)
            2'd0:    w = TW0;
            2'd1:    w = TW1;
            2'd2:    w = TW2;
            default: w = TW3;
        endcase
        return w;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] x);
        return {x[0], x[1], x[2]};
    endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 DIT butterfly with 1/2 scaling and saturation.
// Ports: a, b (inputs), w (twiddle) -> A = (a+b*w)/2, B = (a-b*w)/2.
module ifft_bfly
    import fft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    input  cplx_t w,
    output cplx_t A,
    output cplx_t B
);

    logic signed [31:0] p_rr;
    logic signed [31:0] p_ii;
    logic signed [31:0] p_ri;
    logic signed [31:0] p_ir;
    logic signed [32:0] s_re;
    logic signed [32:0] s_im;
    logic signed [16:0] t_re;
    logic signed [16:0] t_im;
    logic signed [17:0] sum_re;
    logic signed [17:0] sum_im;
    logic signed [17:0] dif_re;
    logic signed [17:0] dif_im;

    // Clamp a 17-bit value into the signed 16-bit range
    function automatic logic [15:0] sat(input logic [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'h8000 : 16'h7FFF;
        end
        return v[15:0];
    endfunction

    assign p_rr = 32'($signed(b.re)) * 32'($signed(w.re));
    assign p_ii = 32'($signed(b.im)) * 32'($signed(w.im));
    assign p_ri = 32'($signed(b.re)) * 32'($signed(w.im));
    assign p_ir = 32'($signed(b.im)) * 32'($signed(w.re));

    assign s_re = 33'(p_rr) - 33'(p_ii);
    assign s_im = 33'(p_ri) + 33'(p_ir);

    // Q2.30 product back to Q.15, flooring
    assign t_re = 17'(s_re >>> 15);
    assign t_im = 17'(s_im >>> 15);

    assign sum_re = 18'($signed(a.re)) + 18'(t_re);
    assign sum_im = 18'($signed(a.im)) + 18'(t_im);
    assign dif_re = 18'($signed(a.re)) - 18'(t_re);
    assign dif_im = 18'($signed(a.im)) - 18'(t_im);

    assign A = {sat(17'(sum_re >>> 1)), sat(17'(sum_im >>> 1))};
    assign B = {sat(17'(dif_re >>> 1)), sat(17'(dif_im >>> 1))};

endmodule

// File: rtl/ifft8_iter.sv
// Iterative 8-point inverse FFT, one shared butterfly, 1/8 overall scale.
// Ports: in_* input stream (X[k]), out_* output stream (y[n]), busy.
module ifft8_iter
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_re,
    output logic [15:0] out_im,
    output logic        busy
);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic [1:0]  stage_q;
    logic [1:0]  stage_d;
    logic [1:0]  bfly_q;
    logic [1:0]  bfly_d;
    cplx_t       mem_q [N];

    logic        in_fire;
    logic        out_fire;
    logic        last_bfly;
    logic [2:0]  top;
    logic [2:0]  bot;
    logic [1:0]  tw_k;
    cplx_t       bf_w;
    cplx_t       bf_A;
    cplx_t       bf_B;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_bfly = (stage_q == 2'd2) && (bfly_q == 2'd3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (in_fire && cnt_q == 3'd7) state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (last_bfly) state_d = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                if (out_fire && cnt_q == 3'd7) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        out_valid = (state_q == ST_UNLOAD);
        busy      = (state_q != ST_LOAD);
        out_re    = '0;
        out_im    = '0;
        if (state_q == ST_UNLOAD) begin
            out_re = mem_q[cnt_q].re;
            out_im = mem_q[cnt_q].im;
        end
    end

    // Counter next-state; cnt wraps to 0 after each 8-sample phase
    always_comb begin
        cnt_d   = cnt_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        if (in_fire || out_fire) cnt_d = cnt_q + 3'd1;
        if (state_q == ST_COMPUTE) begin
            bfly_d = bfly_q + 2'd1;
            if (bfly_q == 2'd3) begin
                stage_d = last_bfly ? 2'd0 : stage_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
        end
    end

    // Butterfly pair and twiddle for (stage, j); bot is top + (1 << stage)
    always_comb begin
        unique case (stage_q)
            2'd0: begin
                top  = {bfly_q, 1'b0};
                bot  = {bfly_q, 1'b1};
                tw_k = 2'd0;
            end
            2'd1: begin
                top  = {bfly_q[1], 1'b0, bfly_q[0]};
                bot  = {bfly_q[1], 1'b1, bfly_q[0]};
                tw_k = {bfly_q[0], 1'b0};
            end
            default: begin
                top  = {1'b0, bfly_q};
                bot  = {1'b1, bfly_q};
                tw_k = bfly_q;
            end
        endcase
    end

    assign bf_w = twiddle(tw_k);

    ifft_bfly u_bfly (
        .a (mem_q[top]),
        .b (mem_q[bot]),
        .w (bf_w),
        .A (bf_A),
        .B (bf_B)
    );

    // Register file: bit-reversed load, in-place butterfly writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (in_fire) begin
            mem_q[bitrev3(cnt_q)] <= {in_re, in_im};
        end else if (state_q == ST_COMPUTE) begin
            mem_q[top] <= bf_A;
            mem_q[bot] <= bf_B;
        end
    end

endmodule

// File: tb/tb_ifft8_iter.sv
// Randomized self-checking bench for ifft8_iter.
// Reference: direct 8-point IDFT in real arithmetic, scaled by 1/8.
module tb_ifft8_iter;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int xr [8];
    int xi [8];
    int er [8];
    int ei [8];

    ifft8_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input int got,
                         input int exp, input int tol);
        int d;
        d = got - exp;
        if (d < 0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s got %0d exp %0d tol %0d", tag, got, exp, tol);
        end
    endtask

    function automatic int clamp16(input real v);
        int r;
        r = int'(v);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // y[n] = 1/8 * sum_k X[k] * exp(+j*2*pi*k*n/8)
    function automatic void model();
        real yr;
        real yi;
        real ang;
        for (int n = 0; n < 8; n++) begin
            yr = 0.0;
            yi = 0.0;
            for (int k = 0; k < 8; k++) begin
                ang = 2.0 * PI * real'(k * n) / 8.0;
                yr += real'(xr[k]) * $cos(ang) - real'(xi[k]) * $sin(ang);
                yi += real'(xr[k]) * $sin(ang) + real'(xi[k]) * $cos(ang);
            end
            er[n] = clamp16(yr / 8.0);
            ei[n] = clamp16(yi / 8.0);
        end
    endfunction

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic push(input int re, input int im);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_re    = 16'(re);
        in_im    = 16'(im);
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("push_rdy", int'(in_ready), 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_re    = $urandom;
        in_im    = $urandom;
    endtask

    task automatic send_all(input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            push(xr[k], xi[k]);
        end
    endtask

    task automatic run_frame(input string name, input bit gaps,
                             input bit bp, input int tol);
        int lat;
        int idx;
        int cyc;
        int stall;
        model();
        out_ready = 1'b0;
        send_all(gaps);
        lat = 0;
        while (!out_valid && lat < 40) begin
            check({name, "_cmp_rdy"}, int'(in_ready), 0, 0);
            check({name, "_cmp_busy"}, int'(busy), 1, 0);
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, lat, 12, 0);
        idx = 0;
        cyc = 0;
        stall = 0;
        while (idx < 8 && cyc < 200) begin
            if (bp && idx == 3 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                check({name, "_hold_v"}, int'(out_valid), 1, 0);
                check({name, "_hold_re"}, s16(out_re), er[3], tol);
                check({name, "_hold_im"}, s16(out_im), ei[3], tol);
            end else if (bp) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid) begin
                check({name, "_unl_rdy"}, int'(in_ready), 0, 0);
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s_re%0d", name, idx), s16(out_re), er[idx], tol);
                check($sformatf("%s_im%0d", name, idx), s16(out_im), ei[idx], tol);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check({name, "_count"}, idx, 8, 0);
        check({name, "_end_v"}, int'(out_valid), 0, 0);
        check({name, "_end_rdy"}, int'(in_ready), 1, 0);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) begin
            xr[k] = int'($urandom_range(0, 16383)) - 8192;
            xi[k] = int'($urandom_range(0, 16383)) - 8192;
        end
    endtask

    task automatic fill(input int re, input int im);
        for (int k = 0; k < 8; k++) begin
            xr[k] = re;
            xi[k] = im;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", int'(in_ready), 1, 0);
        check("rst_ov", int'(out_valid), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_re", int'(out_re), 0, 0);
        check("rst_im", int'(out_im), 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill(0, 0);
        xr[0] = 16'h4000;
        run_frame("imp", 1'b0, 1'b0, 0);

        fill(16'h4000, 0);
        run_frame("dc", 1'b0, 1'b0, 4);

        fill(0, 0);
        xr[1] = 16'h4000;
        run_frame("tone", 1'b0, 1'b0, 4);

        for (int f = 0; f < 3; f++) begin
            rand_frame();
            run_frame($sformatf("rnd%0d", f), 1'b1, 1'b1, 4);
        end

        fill(32767, 32767);
        run_frame("satp", 1'b0, 1'b0, 4);

        fill(-32768, -32768);
        run_frame("satn", 1'b0, 1'b0, 4);

        rand_frame();
        send_all(1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", int'(out_valid), 0, 0);
        check("mid_rst_rdy", int'(in_ready), 1, 0);
        check("mid_rst_busy", int'(busy), 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            check("post_rst_ov", int'(out_valid), 0, 0);
        end

        rand_frame();
        run_frame("after_rst", 1'b1, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
